// File: rtl/display_scan_ctrl_pkg.sv
// Shared segment definitions for the two-digit scan controller:
// bit order, blank pattern and the hex 0-F pattern table.
package display_scan_ctrl_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  // Segment A sits in the MSB, G in the LSB.
  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
  } seg_s;

  typedef enum logic {
    DIG_LO = 1'b0,
    DIG_HI = 1'b1
  } digit_e;

  localparam seg_t SEG_BLANK = 7'h00;

  localparam seg_t SEG_HEX_0 = 7'h7E;
  localparam seg_t SEG_HEX_1 = 7'h30;
  localparam seg_t SEG_HEX_2 = 7'h6D;
  localparam seg_t SEG_HEX_3 = 7'h79;
  localparam seg_t SEG_HEX_4 = 7'h33;
  localparam seg_t SEG_HEX_5 = 7'h5B;
  localparam seg_t SEG_HEX_6 = 7'h5F;
  localparam seg_t SEG_HEX_7 = 7'h70;
  localparam seg_t SEG_HEX_8 = 7'h7F;
  localparam seg_t SEG_HEX_9 = 7'h7B;
  localparam seg_t SEG_HEX_A = 7'h77;
  localparam seg_t SEG_HEX_B = 7'h1F;
  localparam seg_t SEG_HEX_C = 7'h4E;
  localparam seg_t SEG_HEX_D = 7'h3D;
  localparam seg_t SEG_HEX_E = 7'h4F;
  localparam seg_t SEG_HEX_F = 7'h47;

  localparam logic [15:0][SEG_W-1:0] SEG_LUT = {
    SEG_HEX_F, SEG_HEX_E, SEG_HEX_D, SEG_HEX_C,
    SEG_HEX_B, SEG_HEX_A, SEG_HEX_9, SEG_HEX_8,
    SEG_HEX_7, SEG_HEX_6, SEG_HEX_5, SEG_HEX_4,
    SEG_HEX_3, SEG_HEX_2, SEG_HEX_1, SEG_HEX_0
  };

endpackage

// File: rtl/display_scan_ctrl_hex_to_7seg.sv
// Purely combinational hex nibble to active-high seven-segment decoder.
module hex_to_7seg
  import display_scan_ctrl_pkg::*;
(
  input  logic [3:0]       i_hex,
  output logic [SEG_W-1:0] o_seg
);

  seg_s w_pat;

  assign w_pat = SEG_LUT[i_hex];
  assign o_seg = w_pat;

endmodule

// File: rtl/display_scan_ctrl.sv
// Two-digit seven-segment scan controller with anti-ghost blanking and a
// frame-aligned load handshake. Optional: LEADING_ZERO_BLANK_EN.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [3:0]       value_lo,
  input  logic [3:0]       value_hi,
  output logic             ready,
  output logic [SEG_W-1:0] seg,
  output logic             sel
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES);

  logic [PW-1:0]    r_presc;
  digit_e           r_sel;
  logic [BW-1:0]    r_blank;
  logic [3:0]       r_disp_lo, r_disp_hi;
  logic [3:0]       r_shad_lo, r_shad_hi;
  logic             r_ready;
  logic [SEG_W-1:0] r_seg;

  logic             w_term, w_apply, w_accept;
  digit_e           w_sel_nxt;
  logic [BW-1:0]    w_blank_nxt;
  logic [3:0]       w_lo_nxt, w_hi_nxt, w_digit;
  logic [SEG_W-1:0] w_pat, w_seg_nxt;

  assign w_term   = (r_presc == PRESC_LAST);
  // Shadow is only pending while ready is low, so apply and accept never collide.
  assign w_apply  = w_term && (r_sel == DIG_HI) && !r_ready;
  assign w_accept = load && r_ready;

  // The output register is loaded with what the next cycle must show.
  always_comb begin
    w_sel_nxt   = w_term ? digit_e'(~r_sel) : r_sel;
    w_blank_nxt = w_term ? BLANK_LOAD
                : ((r_blank != '0) ? (r_blank - BW'(1)) : '0);
    w_lo_nxt    = w_apply ? r_shad_lo : r_disp_lo;
    w_hi_nxt    = w_apply ? r_shad_hi : r_disp_hi;
    w_digit     = (w_sel_nxt == DIG_HI) ? w_hi_nxt : w_lo_nxt;
  end

  hex_to_7seg u_dec (
    .i_hex (w_digit),
    .o_seg (w_pat)
  );

  always_comb begin
    w_seg_nxt = w_pat;
    if (w_blank_nxt != '0) begin
      w_seg_nxt = SEG_BLANK;
    end
`ifdef LEADING_ZERO_BLANK_EN
    else if ((w_sel_nxt == DIG_HI) && (w_hi_nxt == 4'h0)) begin
      w_seg_nxt = SEG_BLANK;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc   <= '0;
      r_sel     <= DIG_LO;
      r_blank   <= BLANK_LOAD;
      r_disp_lo <= '0;
      r_disp_hi <= '0;
      r_shad_lo <= '0;
      r_shad_hi <= '0;
      r_ready   <= 1'b1;
      r_seg     <= SEG_BLANK;
    end else begin
      r_presc   <= w_term ? '0 : (r_presc + PW'(1));
      r_sel     <= w_sel_nxt;
      r_blank   <= w_blank_nxt;
      r_disp_lo <= w_lo_nxt;
      r_disp_hi <= w_hi_nxt;
      r_seg     <= w_seg_nxt;
      if (w_accept) begin
        r_shad_lo <= value_lo;
        r_shad_hi <= value_hi;
        r_ready   <= 1'b0;
      end else if (w_apply) begin
        r_ready   <= 1'b1;
      end
    end
  end

  assign ready = r_ready;
  assign seg   = r_seg;
  assign sel   = r_sel;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed-plus-random bench for display_scan_ctrl against a cycle-count based
// reference model (CLK_DIV=8, BLANK_CYCLES=2).
module tb_display_scan_ctrl;

  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;
  localparam int FRAME   = 2 * CLK_DIV;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] value_lo = 4'h0;
  logic [3:0] value_hi = 4'h0;
  logic       ready;
  logic [6:0] seg;
  logic       sel;

  int checks = 0;
  int failures = 0;

  // Reference model state: cycles since reset release, displayed/shadow digits.
  int         t;
  logic [3:0] m_lo, m_hi, m_sh_lo, m_sh_hi;
  logic       m_ready;

  logic [6:0] hex_lut [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  always #5 clk = ~clk;

  display_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value_lo (value_lo),
    .value_hi (value_hi),
    .ready    (ready),
    .seg      (seg),
    .sel      (sel)
  );

  function automatic logic exp_sel();
    return logic'((t / CLK_DIV) % 2);
  endfunction

  function automatic logic [6:0] exp_seg();
    if ((t % CLK_DIV) < BLANK) return 7'h00;
    if (exp_sel()) begin
      if (LZB && (m_hi == 4'h0)) return 7'h00;
      return hex_lut[m_hi];
    end
    return hex_lut[m_lo];
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_lo = 4'h0; m_hi = 4'h0; m_sh_lo = 4'h0; m_sh_hi = 4'h0;
    m_ready = 1'b1;
  endtask

  task automatic cycle(input logic l, input logic [3:0] lo, input logic [3:0] hi);
    check("seg", seg, exp_seg());
    check("sel", {6'd0, sel}, {6'd0, exp_sel()});
    check("ready", {6'd0, ready}, {6'd0, m_ready});
    load = l; value_lo = lo; value_hi = hi;
    @(posedge clk);
    if (l && m_ready) begin
      m_sh_lo = lo; m_sh_hi = hi; m_ready = 1'b0;
    end else if ((((t + 1) % FRAME) == 0) && !m_ready) begin
      m_lo = m_sh_lo; m_hi = m_sh_hi; m_ready = 1'b1;
    end
    t++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'($urandom), 4'($urandom));
  endtask

  task automatic bound_fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s t=%0d observed=timeout expected=condition", tag, t);
  endtask

  initial begin
    int n;
    model_reset();
    #12;
    check("rst_seg", seg, 7'h00);
    check("rst_sel", {6'd0, sel}, 7'd0);
    check("rst_ready", {6'd0, ready}, 7'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Load 3/5 right after release, then watch three frames.
    cycle(1'b1, 4'h3, 4'h5);
    idle(3 * FRAME);

    // Free run with changing but unloaded inputs.
    idle(64);

    // Second load while busy must be ignored.
    cycle(1'b1, 4'h1, 4'h2);
    cycle(1'b1, 4'h9, 4'h9);
    idle(2 * FRAME + 8);

    // Load in the exact cycle of the 1->0 frame boundary.
    n = 0;
    while (!(m_ready && (((t + 1) % FRAME) == 0)) && n < 4 * FRAME) begin
      cycle(1'b0, 4'h0, 4'h0);
      n++;
    end
    if (n >= 4 * FRAME) bound_fail("boundary_wait");
    else cycle(1'b1, 4'hA, 4'hF);
    idle(3 * FRAME);

    // Asynchronous reset mid-phase while a segment pattern is lit.
    n = 0;
    while (exp_seg() == 7'h00 && n < 2 * FRAME) begin
      cycle(1'b0, 4'h0, 4'h0);
      n++;
    end
    if (n >= 2 * FRAME) bound_fail("lit_wait");
    check("pre_rst_seg", seg, exp_seg());
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_seg", seg, 7'h00);
    check("async_rst_sel", {6'd0, sel}, 7'd0);
    check("async_rst_ready", {6'd0, ready}, 7'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(FRAME + 4);

    // Leading-zero high digit.
    cycle(1'b1, 4'h4, 4'h0);
    idle(3 * FRAME);

    // Random loads and values.
    for (int i = 0; i < 300; i++)
      cycle(($urandom_range(0, 3) == 0), 4'($urandom), 4'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
